// File: rtl/ifid_hazard_stage_pkg.sv
// Shared constants for the IF/ID stage and its load-use hazard detector.
package ifid_hazard_stage_pkg;

  // Opcodes the hazard logic cares about
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LW    = 6'h23;

  // Instruction field slices
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_STALL = 1'b1
  } state_t;

  // Instructions whose rt field is a source operand rather than a destination
  function automatic logic op_uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/ifid_hazard_stage_hazard_detect.sv
// Combinational load-use hazard check between the instruction in decode and a
// load in EX. Kept separate so a forwarding unit can reuse it.
import ifid_hazard_stage_pkg::*;

module hazard_detect (
  input  logic       i_valid,
  input  logic [5:0] i_op,
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rt,
  input  logic       i_idex_mem_read,
  input  logic [4:0] i_idex_rt,
  output logic       o_uses_rt,
  output logic       o_hazard
);

  logic w_rs_match;
  logic w_rt_match;

  // Register $0 is never a real dependency; bubbles never raise a hazard
  always_comb begin
    o_uses_rt  = op_uses_rt(i_op);
    w_rs_match = (i_idex_rt == i_rs);
    w_rt_match = o_uses_rt && (i_idex_rt == i_rt);
    o_hazard   = i_valid && i_idex_mem_read && (i_idex_rt != 5'd0) &&
                 (w_rs_match || w_rt_match);
  end

endmodule

// File: rtl/ifid_hazard_stage.sv
// IF/ID pipeline register with load-use stall insertion and branch flush.
// state   | meaning
// S_RUN   | normal flow; hazard evaluated each cycle
// S_STALL | one bubble inserted; register reloads next edge, hazard ignored
import ifid_hazard_stage_pkg::*;

module ifid_hazard_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              PCSrc,
  input  logic [DATA_W-1:0] InstructionIn,
  input  logic [DATA_W-1:0] PCPlus4In,
  input  logic              IDEX_MemRead,
  input  logic [4:0]        IDEX_Rt,
  output logic [DATA_W-1:0] InstructionOut,
  output logic [DATA_W-1:0] PCPlus4Out,
  output logic              ValidOut,
  output logic              PCWrite,
  output logic              ControlZero,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_pc4;
  logic              r_valid;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_hazard;
  logic w_uses_rt;
  logic w_stall;
  logic w_load;
  logic w_flush;

  hazard_detect u_hazard_detect (
    .i_valid         (r_valid),
    .i_op            (r_instr[OP_MSB:OP_LSB]),
    .i_rs            (r_instr[RS_MSB:RS_LSB]),
    .i_rt            (r_instr[RT_MSB:RT_LSB]),
    .i_idex_mem_read (IDEX_MemRead),
    .i_idex_rt       (IDEX_Rt),
    .o_uses_rt       (w_uses_rt),
    .o_hazard        (w_hazard)
  );

  // Next-state and register-update selection; flush beats stall, reset beats both
  always_comb begin
    w_next_state = S_RUN;
    w_load       = 1'b0;
    w_flush      = 1'b0;
    w_stall      = 1'b0;
    if (Rst) begin
      unique case (r_state)
        S_RUN: begin
          if (PCSrc) begin
            w_flush = 1'b1;
          end else if (w_hazard) begin
            w_stall      = 1'b1;
            w_next_state = S_STALL;
          end else begin
            w_load = 1'b1;
          end
        end
        S_STALL: begin
          if (PCSrc) w_flush = 1'b1;
          else       w_load  = 1'b1;
        end
        default: w_next_state = S_RUN;
      endcase
    end
  end

  // State register
  always_ff @(posedge Clk) begin
    if (!Rst) r_state <= S_RUN;
    else      r_state <= w_next_state;
  end

  // Pipeline register: load, hold on stall, zero on flush
  always_ff @(posedge Clk) begin
    if (!Rst || w_flush) begin
      r_instr <= '0;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_instr <= InstructionIn;
      r_pc4   <= PCPlus4In;
      r_valid <= 1'b1;
    end
  end

  // Saturating event counters
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && (r_flush_cnt != CNT_MAX)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign InstructionOut = r_instr;
  assign PCPlus4Out     = r_pc4;
  assign ValidOut       = r_valid;
  assign PCWrite        = !w_stall;
  assign ControlZero    = w_stall;
  assign StallCount     = r_stall_cnt;
  assign FlushCount     = r_flush_cnt;

endmodule

// File: tb/tb_ifid_hazard_stage.sv
// Directed bench for the IF/ID hazard stage. Counters are built 8 bits wide
// here so saturation is reachable in a short run.
module tb_ifid_hazard_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              PCSrc;
  logic [DATA_W-1:0] InstructionIn;
  logic [DATA_W-1:0] PCPlus4In;
  logic              IDEX_MemRead;
  logic [4:0]        IDEX_Rt;
  logic [DATA_W-1:0] InstructionOut;
  logic [DATA_W-1:0] PCPlus4Out;
  logic              ValidOut;
  logic              PCWrite;
  logic              ControlZero;
  logic [CNT_W-1:0]  StallCount;
  logic [CNT_W-1:0]  FlushCount;

  int n_total = 0;
  int n_bad   = 0;

  ifid_hazard_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .PCSrc(PCSrc),
    .InstructionIn(InstructionIn), .PCPlus4In(PCPlus4In),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .InstructionOut(InstructionOut), .PCPlus4Out(PCPlus4Out),
    .ValidOut(ValidOut), .PCWrite(PCWrite), .ControlZero(ControlZero),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Load an instruction into the stage with no hazard and no flush
  task automatic load_instr(input logic [31:0] instr, input logic [31:0] pc4);
    PCSrc = 1'b0; IDEX_MemRead = 1'b0; IDEX_Rt = 5'd0;
    InstructionIn = instr; PCPlus4In = pc4;
    tick();
    chk("load_instr", InstructionOut, instr);
    chk("load_pc4", PCPlus4Out, pc4);
    chk("load_valid", {31'b0, ValidOut}, 32'd1);
  endtask

  // Probe the combinational stall decision for the current ID/EX inputs
  task automatic probe(input string tag, input logic mr, input logic [4:0] rt,
                       input logic pcsrc, input logic exp_stall);
    IDEX_MemRead = mr; IDEX_Rt = rt; PCSrc = pcsrc;
    settle();
    chk({tag, "_pcwrite"}, {31'b0, PCWrite}, {31'b0, !exp_stall});
    chk({tag, "_czero"}, {31'b0, ControlZero}, {31'b0, exp_stall});
  endtask

  initial begin
    Rst = 1'b0; PCSrc = 1'b0; IDEX_MemRead = 1'b0; IDEX_Rt = 5'd0;
    InstructionIn = 32'h0108_4820; PCPlus4In = 32'h0000_0004;

    // 1. reset held two cycles
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_instr", InstructionOut, 32'd0);
      chk("rst_pc4", PCPlus4Out, 32'd0);
      chk("rst_valid", {31'b0, ValidOut}, 32'd0);
      chk("rst_pcwrite", {31'b0, PCWrite}, 32'd1);
      chk("rst_czero", {31'b0, ControlZero}, 32'd0);
      chk("rst_stallcnt", {24'b0, StallCount}, 32'd0);
      chk("rst_flushcnt", {24'b0, FlushCount}, 32'd0);
    end
    Rst = 1'b1;
    tick();
    chk("rel_instr", InstructionOut, 32'h0108_4820);
    chk("rel_valid", {31'b0, ValidOut}, 32'd1);

    // 2. load-use on add $9,$8,$8 with lw into $8
    InstructionIn = 32'h2109_0004; PCPlus4In = 32'h0000_0008;
    probe("lu", 1'b1, 5'd8, 1'b0, 1'b1);
    tick();
    chk("lu_hold", InstructionOut, 32'h0108_4820);
    chk("lu_stallcnt", {24'b0, StallCount}, 32'd1);
    chk("lu_stall_state_pcwrite", {31'b0, PCWrite}, 32'd1);
    chk("lu_stall_state_czero", {31'b0, ControlZero}, 32'd0);
    tick();
    chk("lu_reload", InstructionOut, 32'h2109_0004);
    chk("lu_reload_pc4", PCPlus4Out, 32'h0000_0008);
    chk("lu_stallcnt2", {24'b0, StallCount}, 32'd1);

    // 3. addi $9,$8,4: rt is a destination, rs is a source
    probe("addi_rt9", 1'b1, 5'd9, 1'b0, 1'b0);
    probe("addi_rs8", 1'b1, 5'd8, 1'b0, 1'b1);
    probe("nonload", 1'b0, 5'd8, 1'b0, 1'b0);

    // rt used as source by R-type, SW; not by LW
    load_instr(32'h0109_4820, 32'h0000_000C);
    probe("rtype_rt", 1'b1, 5'd9, 1'b0, 1'b1);
    probe("rtype_other", 1'b1, 5'd10, 1'b0, 1'b0);
    load_instr(32'hAD09_0000, 32'h0000_0010);
    probe("sw_rt", 1'b1, 5'd9, 1'b0, 1'b1);
    load_instr(32'h1109_0003, 32'h0000_0014);
    probe("beq_rt", 1'b1, 5'd9, 1'b0, 1'b1);
    load_instr(32'h8D09_0000, 32'h0000_0018);
    probe("lw_rt", 1'b1, 5'd9, 1'b0, 1'b0);

    // 4. $zero never stalls
    load_instr(32'h0000_4820, 32'h0000_001C);
    probe("zero_rt", 1'b1, 5'd0, 1'b0, 1'b0);

    // 5. flush wins over hazard
    load_instr(32'h0108_4820, 32'h0000_0020);
    probe("flush_wins", 1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    chk("flush_instr", InstructionOut, 32'd0);
    chk("flush_pc4", PCPlus4Out, 32'd0);
    chk("flush_valid", {31'b0, ValidOut}, 32'd0);
    chk("flush_cnt", {24'b0, FlushCount}, 32'd1);
    chk("flush_stallcnt", {24'b0, StallCount}, 32'd1);

    // flush while in STALL returns to RUN
    load_instr(32'h0108_4820, 32'h0000_0024);
    probe("pre_stall", 1'b1, 5'd8, 1'b0, 1'b1);
    tick();
    chk("stall2_cnt", {24'b0, StallCount}, 32'd2);
    probe("stall_flush", 1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    chk("stall_flush_instr", InstructionOut, 32'd0);
    chk("stall_flush_cnt", {24'b0, FlushCount}, 32'd2);
    load_instr(32'h0108_4820, 32'h0000_0028);
    probe("back_in_run", 1'b1, 5'd8, 1'b0, 1'b1);

    // 6. stall saturation: each pair of cycles is one stall then a reload
    for (int i = 0; i < 2 * 258; i++) tick();
    chk("stall_sat", {24'b0, StallCount}, 32'h0000_00FF);
    tick();
    chk("in_stall_pcwrite", {31'b0, PCWrite}, 32'd1);
    chk("in_stall_hold", InstructionOut, 32'h0108_4820);
    Rst = 1'b0;
    tick();
    chk("midrst_valid", {31'b0, ValidOut}, 32'd0);
    chk("midrst_instr", InstructionOut, 32'd0);
    chk("midrst_stallcnt", {24'b0, StallCount}, 32'd0);
    chk("midrst_flushcnt", {24'b0, FlushCount}, 32'd0);
    Rst = 1'b1;
    tick();
    chk("postrst_valid", {31'b0, ValidOut}, 32'd1);
    chk("postrst_run", {31'b0, ControlZero}, 32'd1);

    // flush saturation
    PCSrc = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    chk("flush_sat", {24'b0, FlushCount}, 32'h0000_00FF);
    chk("flush_sat_stallcnt", {24'b0, StallCount}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ifid_hazard_stage.md
Name: ifid_hazard_stage

Overview:
- IF/ID pipeline register for the pipelined MIPS SAD datapath, merged with load-use hazard detection.
- Sits between instruction fetch and decode.
- Captures the fetched instruction and PC+4, and holds them for one cycle when the decoded instruction depends on a load now in EX.
- Zeroes its contents when a taken branch/jump (PCSrc) flushes the pipe.
- Drives PC write-enable and the bubble select that zeroes control fields entering the ID/EX register.

Parameters:
- DATA_W, 32, instruction and PC width.
- CNT_W, 16, width of the saturating stall and flush event counters.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-low reset; takes effect at the Clk edge while low.
- PCSrc  input  1  taken branch/jump; flushes this stage.
- InstructionIn  input  DATA_W  fetched instruction.
- PCPlus4In  input  DATA_W  fetch PC+4.
- IDEX_MemRead  input  1  instruction now in ID/EX is a load.
- IDEX_Rt  input  5  load destination register in ID/EX.
- InstructionOut  output  DATA_W  registered instruction to decode.
- PCPlus4Out  output  DATA_W  registered PC+4.
- ValidOut  output  1  InstructionOut is a real instruction, not a bubble.
- PCWrite  output  1  PC register enable; 0 during stall.
- ControlZero  output  1  selects all-zero control into ID/EX (bubble).
- StallCount  output  CNT_W  number of stall cycles inserted, saturating.
- FlushCount  output  CNT_W  number of flush cycles, saturating.

Behaviour:
- Reset (Rst==0 at edge):
  - InstructionOut=0, PCPlus4Out=0, ValidOut=0.
  - State=RUN, StallCount=0, FlushCount=0.
  - Reset overrides PCSrc and stall.
- Combinational outputs during reset cycles: PCWrite=1, ControlZero=0.
- Decode fields of InstructionOut: op=[31:26], rs=[25:21], rt=[20:16].
- usesRt=1 when op is R-type (0x00), BEQ (0x04), BNE (0x05) or SW (0x2B); otherwise 0.
- Hazard (combinational):
  - Requires ValidOut && IDEX_MemRead && IDEX_Rt!=0.
  - And either IDEX_Rt==rs, or (usesRt && IDEX_Rt==rt).
- Stall = (state==RUN) && Hazard && !PCSrc.
- PCWrite = !Stall. ControlZero = Stall.
- FSM, 2 states:
  - RUN: if PCSrc, then flush and stay in RUN. Else if Stall, hold register and go to STALL. Else load InstructionIn/PCPlus4In, set ValidOut=1, stay in RUN.
  - STALL: hazard is not re-evaluated, so Stall=0 and PCWrite=1. If PCSrc, flush and go to RUN. Else load new inputs and go to RUN.
  - Guarantees exactly one bubble per load-use.
- Flush:
  - InstructionOut=0, PCPlus4Out=0, ValidOut=0.
  - FlushCount increments, saturating at 2^CNT_W-1.
- Stall: StallCount increments each Stall cycle, saturating.
- PCSrc and hazard in the same cycle: flush wins. No stall, ControlZero=0, StallCount unchanged.
- Latency: 1 cycle from input to output when not stalled.
- A bubble (ValidOut=0) never raises Hazard.

Decomposition:
- Shared package holds:
  - Opcode constants OP_RTYPE=6'h00, OP_BEQ=6'h04, OP_BNE=6'h05, OP_SW=6'h2B, OP_LW=6'h23.
  - State encoding S_RUN=1'b0, S_STALL=1'b1.
  - Field slice constants.
- One natural sub-module: hazard_detect, the combinational Hazard/usesRt logic, reusable by a future forwarding unit.
- The counters stay inline.

Test Plan:
1. Reset: hold Rst=0 for 2 cycles with InstructionIn=0x01084820 -> all outputs 0, PCWrite=1, counters 0. Release Rst -> next edge InstructionOut=0x01084820, ValidOut=1.
2. Load-use via rs and rt: IDEX_MemRead=1, IDEX_Rt=8, InstructionOut=0x01084820 (add $9,$8,$8) -> PCWrite=0, ControlZero=1 for exactly 1 cycle. Register holds. StallCount=1. Next cycle loads new input.
3. No hazard on rt for I-type: InstructionOut=0x21090004 (addi $9,$8,4), IDEX_Rt=9, MemRead=1 -> Stall=0. With IDEX_Rt=8 -> Stall=1.
4. $zero and non-load: IDEX_Rt=0 with MemRead=1 against rs=0 -> no stall. IDEX_Rt=8 with MemRead=0 -> no stall.
5. Flush wins: Hazard true and PCSrc=1 in the same cycle -> PCWrite=1, ControlZero=0. Next edge InstructionOut=0, ValidOut=0, FlushCount=1, StallCount unchanged. PCSrc in STALL state -> flush and return to RUN.
6. Saturation and reset mid-stall: force 0xFFFF+3 stall events -> StallCount stays 0xFFFF. Assert Rst=0 while in STALL -> next edge state RUN, counters 0, ValidOut=0.
